queue_fwft: RTL and testbench

Parametrised synchronous FIFO, successor to the single-mode queue. Adds a selectable first-word-fall-through read mode, programmable almost-full/almost-empty thresholds, an occupancy output, a synchronous flush, and sticky overflow/underflow error flags. It sits between any producer/consumer pair in one clock domain, such as UART byte buffers or bus-bridge command queues.

---
 rtl/queue_mem.sv | 33 +++
 rtl/queue_fwft.sv | 119 +++++++++++
 tb/tb_queue_fwft.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/queue_mem.sv
// ============================================================================
// queue_mem : DEPTH x DATA_BITS register file, sync write / async read
// Revision  : 1.0
// ============================================================================
`default_nettype none

module queue_mem #(
  parameter int DEPTH_BITS = 3,
  parameter int DATA_BITS  = 8
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [DEPTH_BITS-1:0] wr_addr,
  input  logic [DATA_BITS-1:0]  wr_data,
  input  logic [DEPTH_BITS-1:0] rd_addr,
  output logic [DATA_BITS-1:0]  rd_data
);

  localparam int DEPTH = 1 << DEPTH_BITS;

  logic [DATA_BITS-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

`default_nettype wire

// File: rtl/queue_fwft.sv
// ============================================================================
// queue_fwft : synchronous FIFO with registered or fall-through read mode
// Revision   : 1.0
// ============================================================================
`default_nettype none

module queue_fwft #(
  parameter int DEPTH_BITS = 3,
  parameter int DATA_BITS  = 8,
  parameter bit FWFT       = 1'b0,
  parameter int AF_LEVEL   = (1 << DEPTH_BITS) - 2,
  parameter int AE_LEVEL   = 1
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic [DATA_BITS-1:0]  dat_i,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic                  oe_i,
  input  logic                  flush_i,
  output logic [DATA_BITS-1:0]  dat_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic [DEPTH_BITS:0]   level_o,
  output logic                  ovf_o,
  output logic                  udf_o,
  output logic [DEPTH_BITS-1:0] rp_to,
  output logic [DEPTH_BITS-1:0] wp_to
);

  localparam logic [DEPTH_BITS:0] DEPTH_LVL = {1'b1, {DEPTH_BITS{1'b0}}};
  localparam logic [DEPTH_BITS:0] AF_LVL    = AF_LEVEL[DEPTH_BITS:0];
  localparam logic [DEPTH_BITS:0] AE_LVL    = AE_LEVEL[DEPTH_BITS:0];

  logic [DEPTH_BITS-1:0] rp;
  logic [DEPTH_BITS-1:0] wp;
  logic [DEPTH_BITS:0]   level;
  logic                  ovf;
  logic                  udf;
  logic                  pop_acc;
  logic                  push_acc;
  logic                  wr_en;
  logic [DATA_BITS-1:0]  rd_data;

  // A pop on a full queue frees the slot the simultaneous push lands in.
  assign pop_acc  = pop_i & (level != '0);
  assign push_acc = push_i & ((level != DEPTH_LVL) | pop_acc);
  assign wr_en    = push_acc & ~flush_i;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      rp    <= '0;
      wp    <= '0;
      level <= '0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else if (flush_i) begin
      rp    <= '0;
      wp    <= '0;
      level <= '0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else begin
      if (push_acc) wp <= wp + 1'b1;
      if (pop_acc)  rp <= rp + 1'b1;
      case ({push_acc, pop_acc})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (push_i & ~push_acc) ovf <= 1'b1;
      if (pop_i & ~pop_acc)   udf <= 1'b1;
    end
  end

  queue_mem #(
    .DEPTH_BITS (DEPTH_BITS),
    .DATA_BITS  (DATA_BITS)
  ) u_mem (
    .clk     (clk_i),
    .wr_en   (wr_en),
    .wr_addr (wp),
    .wr_data (dat_i),
    .rd_addr (rp),
    .rd_data (rd_data)
  );

  generate
    if (FWFT) begin : g_fwft
      assign dat_o = rd_data;
    end else begin : g_reg
      logic [DATA_BITS-1:0] dat_q;
      // Reads the pre-edge head regardless of occupancy; flush leaves it alone.
      always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
          dat_q <= '0;
        end else if (oe_i && !flush_i) begin
          dat_q <= rd_data;
        end
      end
      assign dat_o = dat_q;
    end
  endgenerate

  assign full_o         = (level == DEPTH_LVL);
  assign empty_o        = (level == '0);
  assign almost_full_o  = (level >= AF_LVL);
  assign almost_empty_o = (level <= AE_LVL);
  assign level_o        = level;
  assign ovf_o          = ovf;
  assign udf_o          = udf;
  assign rp_to          = rp;
  assign wp_to          = wp;

endmodule

`default_nettype wire

// File: tb/tb_queue_fwft.sv
// ============================================================================
// tb_queue_fwft : directed self-checking bench, registered and FWFT instances
// Revision      : 1.0
// ============================================================================
`default_nettype none

module tb_queue_fwft;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] dat;
  logic       push, pop, oe, flush;

  logic [7:0] d0, d1;
  logic       full0, empty0, af0, ae0, ovf0, udf0;
  logic       full1, empty1, af1, ae1, ovf1, udf1;
  logic [3:0] lvl0, lvl1;
  logic [2:0] rp0, wp0, rp1, wp1;

  int tests = 0;
  int errors = 0;

  always #5 clk = ~clk;

  queue_fwft #(.DEPTH_BITS(3), .DATA_BITS(8), .FWFT(1'b0), .AF_LEVEL(6), .AE_LEVEL(1)) u_reg (
    .clk_i(clk), .reset_ni(rst_n), .dat_i(dat), .push_i(push), .pop_i(pop), .oe_i(oe),
    .flush_i(flush), .dat_o(d0), .full_o(full0), .empty_o(empty0), .almost_full_o(af0),
    .almost_empty_o(ae0), .level_o(lvl0), .ovf_o(ovf0), .udf_o(udf0), .rp_to(rp0), .wp_to(wp0)
  );

  queue_fwft #(.DEPTH_BITS(3), .DATA_BITS(8), .FWFT(1'b1), .AF_LEVEL(6), .AE_LEVEL(1)) u_fwft (
    .clk_i(clk), .reset_ni(rst_n), .dat_i(dat), .push_i(push), .pop_i(pop), .oe_i(oe),
    .flush_i(flush), .dat_o(d1), .full_o(full1), .empty_o(empty1), .almost_full_o(af1),
    .almost_empty_o(ae1), .level_o(lvl1), .ovf_o(ovf1), .udf_o(udf1), .rp_to(rp1), .wp_to(wp1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    push = 1'b0; pop = 1'b0; oe = 1'b0; flush = 1'b0;
  endtask

  task automatic do_flush();
    idle(); flush = 1'b1; tick(); flush = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; dat = 8'h00; idle();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("rst_level", 32'(lvl0), 0);
    check("rst_empty", 32'(empty0), 1);
    check("rst_ae", 32'(ae0), 1);
    check("rst_full", 32'(full0), 0);
    check("rst_af", 32'(af0), 0);
    check("rst_ovf", 32'(ovf0), 0);
    check("rst_udf", 32'(udf0), 0);
    check("rst_rp", 32'(rp0), 0);
    check("rst_wp", 32'(wp0), 0);
    check("rst_dat", 32'(d0), 0);

    // Fill 0x10..0x17
    for (int i = 0; i < 8; i++) begin
      dat = 8'h10 + 8'(i); push = 1'b1; tick();
      check("fill_level", 32'(lvl0), 32'(i + 1));
      check("fill_af", 32'(af0), (i + 1 >= 6) ? 1 : 0);
      check("fill_full", 32'(full0), (i + 1 == 8) ? 1 : 0);
    end
    check("fill_wp_wrap", 32'(wp0), 0);
    check("fill_ovf_pre", 32'(ovf0), 0);
    dat = 8'hEE; tick();
    push = 1'b0;
    check("ovf_set", 32'(ovf0), 1);
    check("ovf_level", 32'(lvl0), 8);

    // Drain with oe
    for (int i = 0; i < 8; i++) begin
      pop = 1'b1; oe = 1'b1; tick();
      check("drain_dat", 32'(d0), 32'(8'h10 + 8'(i)));
      check("drain_level", 32'(lvl0), 32'(7 - i));
    end
    oe = 1'b0; tick();
    pop = 1'b0;
    check("drain_rp_wrap", 32'(rp0), 0);
    check("drain_empty", 32'(empty0), 1);
    check("udf_set", 32'(udf0), 1);
    check("ovf_sticky", 32'(ovf0), 1);
    do_flush();
    check("flush_ovf", 32'(ovf0), 0);
    check("flush_udf", 32'(udf0), 0);
    check("flush_dat_hold", 32'(d0), 32'h17);

    // Full queue, simultaneous push+pop
    for (int i = 0; i < 8; i++) begin
      dat = 8'h20 + 8'(i); push = 1'b1; tick();
    end
    dat = 8'hAA; push = 1'b1; pop = 1'b1; tick();
    idle();
    check("fpp_level", 32'(lvl0), 8);
    check("fpp_full", 32'(full0), 1);
    check("fpp_ovf", 32'(ovf0), 0);
    check("fpp_rp", 32'(rp0), 1);
    check("fpp_wp", 32'(wp0), 1);
    do_flush();

    // Empty queue, simultaneous push+pop
    dat = 8'h55; push = 1'b1; pop = 1'b1; tick();
    idle();
    check("epp_level", 32'(lvl0), 1);
    check("epp_rp", 32'(rp0), 0);
    check("epp_udf", 32'(udf0), 1);
    oe = 1'b1; tick(); oe = 1'b0;
    check("epp_dat", 32'(d0), 32'h55);
    do_flush();

    // FWFT instance: fall-through
    dat = 8'h3C; push = 1'b1; tick();
    push = 1'b0;
    check("fwft_dat", 32'(d1), 32'h3C);
    check("fwft_empty0", 32'(empty1), 0);
    check("reg_dat_not_loaded", 32'(d0), 32'h55);
    pop = 1'b1; tick(); pop = 1'b0;
    check("fwft_empty1", 32'(empty1), 1);
    do_flush();

    // Flush with push held at level 5, flags previously set
    pop = 1'b1; tick(); pop = 1'b0;
    check("pre_udf", 32'(udf0), 1);
    for (int i = 0; i < 5; i++) begin
      dat = 8'h40 + 8'(i); push = 1'b1; tick();
    end
    check("l5_level", 32'(lvl0), 5);
    flush = 1'b1; tick();
    idle();
    check("fl_level", 32'(lvl0), 0);
    check("fl_rp", 32'(rp0), 0);
    check("fl_wp", 32'(wp0), 0);
    check("fl_udf", 32'(udf0), 0);
    check("fl_empty", 32'(empty0), 1);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) begin
      dat = 8'h60 + 8'(i); push = 1'b1; tick();
    end
    push = 1'b0; pop = 1'b1; oe = 1'b1; tick();
    idle();
    check("ar_pre_dat", 32'(d0), 32'h60);
    check("ar_pre_level", 32'(lvl0), 2);
    #2 rst_n = 1'b0;
    #1;
    check("ar_level", 32'(lvl0), 0);
    check("ar_empty", 32'(empty0), 1);
    check("ar_ae", 32'(ae0), 1);
    check("ar_rp", 32'(rp0), 0);
    check("ar_wp", 32'(wp0), 0);
    check("ar_dat", 32'(d0), 0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

`default_nettype wire
